// File: rtl/adc045_emu.sv
// adc045_emu: device-side emulator of the ADC045 converter.
//   Paces conversions from a free-running timer, pulses DRDY, shifts DATA_W-bit
//   samples MSB-first on DOUT (changing on SCLK fall) and decodes 16-bit host
//   register-write commands arriving on DIN (sampled on SCLK rise).
// Ports:
//   clk, rst_l            system clock, asynchronous active-low reset
//   SCLK, CS, DIN         host serial link inputs (asynchronous, synchronised here)
//   DOUT, DRDY            serial sample data out, data-ready pulse
//   nRST, START           host soft reset (active-low) and conversion enable
//   ch0_sample/ch1_sample parallel sample sources selected by a_mux
//   a_mux                 register 0x01 bit0
//   conv_stb, reg_wr      1-clk strobes: sample latched, register written
//   reg_addr, reg_data    address/data of the last register write
//   overrun               1-clk strobe: conversion landed while a frame was shifting
module adc045_emu #(
    parameter int unsigned DATA_W   = 24,
    parameter int unsigned CONV_DIV = 100,
    parameter int unsigned DRDY_LEN = 4
) (
    input  logic              clk,
    input  logic              rst_l,
    input  logic              SCLK,
    input  logic              CS,
    input  logic              DIN,
    output logic              DOUT,
    output logic              DRDY,
    input  logic              nRST,
    input  logic              START,
    input  logic [DATA_W-1:0] ch0_sample,
    input  logic [DATA_W-1:0] ch1_sample,
    output logic              a_mux,
    output logic              conv_stb,
    output logic              reg_wr,
    output logic [6:0]        reg_addr,
    output logic [7:0]        reg_data,
    output logic              overrun
);

    localparam int unsigned TMR_W  = (CONV_DIV > 1) ? $clog2(CONV_DIV) : 1;
    localparam int unsigned BCNT_W = $clog2(DATA_W + 1);
    localparam int unsigned DCNT_W = $clog2(DRDY_LEN + 1);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    // Synchronisers; the third SCLK/CS stage is the previous synchronised value
    // used for edge detection.
    logic [2:0] r_sclk_s;
    logic [2:0] r_cs_s;
    logic [1:0] r_din_s;
    logic [1:0] r_nrst_s;
    logic [1:0] r_start_s;

    logic [TMR_W-1:0]  r_timer;
    logic [DCNT_W-1:0] r_drdy_cnt;
    logic [DATA_W-1:0] r_hold;
    logic [DATA_W-1:0] r_shift;
    logic [BCNT_W-1:0] r_bit_cnt;
    logic [14:0]       r_cmd;
    state_t            r_state;

    logic              w_sclk_rise;
    logic              w_sclk_fall;
    logic              w_cs_rise;
    logic              w_cs_n;
    logic              w_din;
    logic              w_nrst;
    logic              w_start;
    logic              w_conv;
    logic [DATA_W-1:0] w_sample;
    logic [DATA_W-1:0] w_hold_nxt;
    logic [15:0]       w_cmd_nxt;

    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            r_sclk_s  <= '0;
            r_cs_s    <= '1;
            r_din_s   <= '0;
            r_nrst_s  <= '0;
            r_start_s <= '0;
        end else begin
            r_sclk_s  <= {r_sclk_s[1:0], SCLK};
            r_cs_s    <= {r_cs_s[1:0], CS};
            r_din_s   <= {r_din_s[0], DIN};
            r_nrst_s  <= {r_nrst_s[0], nRST};
            r_start_s <= {r_start_s[0], START};
        end
    end

    always_comb begin
        w_sclk_rise = r_sclk_s[1] & ~r_sclk_s[2];
        w_sclk_fall = ~r_sclk_s[1] & r_sclk_s[2];
        w_cs_rise   = r_cs_s[1] & ~r_cs_s[2];
        w_cs_n      = r_cs_s[1];
        w_din       = r_din_s[1];
        w_nrst      = r_nrst_s[1];
        w_start     = r_start_s[1];
        w_conv      = w_nrst & w_start & (r_timer == TMR_W'(CONV_DIV - 1));
        w_sample    = a_mux ? ch1_sample : ch0_sample;
        // Word the shifter should see this cycle: a conversion in the same clk
        // wins over the previous hold value.
        w_hold_nxt  = w_conv ? w_sample : r_hold;
        w_cmd_nxt   = {r_cmd, w_din};
    end

    // Conversion pacing: timer, sample hold, DRDY stretch.
    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            r_timer    <= '0;
            r_drdy_cnt <= '0;
            r_hold     <= '0;
            conv_stb   <= 1'b0;
            DRDY       <= 1'b0;
        end else if (!w_nrst) begin
            r_timer    <= '0;
            r_drdy_cnt <= '0;
            r_hold     <= '0;
            conv_stb   <= 1'b0;
            DRDY       <= 1'b0;
        end else begin
            conv_stb <= w_conv;
            if (w_start) begin
                r_timer <= w_conv ? '0 : r_timer + TMR_W'(1);
            end
            if (w_conv) begin
                r_hold     <= w_sample;
                DRDY       <= 1'b1;
                r_drdy_cnt <= DCNT_W'(DRDY_LEN - 1);
            end else if (r_drdy_cnt != '0) begin
                r_drdy_cnt <= r_drdy_cnt - DCNT_W'(1);
            end else begin
                DRDY <= 1'b0;
            end
        end
    end

    // Frame FSM, command decode and register file.
    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            r_state   <= IDLE;
            r_bit_cnt <= '0;
            r_shift   <= '0;
            r_cmd     <= '0;
            DOUT      <= 1'b0;
            a_mux     <= 1'b0;
            reg_wr    <= 1'b0;
            reg_addr  <= '0;
            reg_data  <= '0;
            overrun   <= 1'b0;
        end else begin
            reg_wr  <= 1'b0;
            overrun <= 1'b0;
            if (!w_nrst) begin
                r_state   <= IDLE;
                r_bit_cnt <= '0;
                r_shift   <= '0;
                r_cmd     <= '0;
                DOUT      <= 1'b0;
                a_mux     <= 1'b0;
            end else if (w_cs_rise) begin
                r_state   <= IDLE;
                r_bit_cnt <= '0;
                r_cmd     <= '0;
                r_shift   <= w_hold_nxt;
                DOUT      <= w_hold_nxt[DATA_W-1];
            end else begin
                case (r_state)
                    IDLE: begin
                        // Shifter tracks the hold register while idle, which also
                        // picks up a sample that arrived during an overrun.
                        r_shift <= w_hold_nxt;
                        DOUT    <= w_hold_nxt[DATA_W-1];
                        if (w_sclk_rise && !w_cs_n) begin
                            r_state   <= SHIFT;
                            r_bit_cnt <= BCNT_W'(1);
                            r_cmd     <= {14'd0, w_din};
                        end
                    end
                    SHIFT: begin
                        if (w_conv) begin
                            overrun <= 1'b1;
                        end
                        if (w_sclk_rise) begin
                            if (r_bit_cnt < BCNT_W'(16)) begin
                                r_cmd <= w_cmd_nxt[14:0];
                            end
                            // Rise with bit_cnt==15 is the 16th: command complete.
                            if (r_bit_cnt == BCNT_W'(15) && w_cmd_nxt[15]) begin
                                reg_wr   <= 1'b1;
                                reg_addr <= w_cmd_nxt[14:8];
                                reg_data <= w_cmd_nxt[7:0];
                                if (w_cmd_nxt[14:8] == 7'h01) begin
                                    a_mux <= w_cmd_nxt[0];
                                end
                            end
                            if (r_bit_cnt == BCNT_W'(DATA_W - 1)) begin
                                r_state   <= IDLE;
                                r_bit_cnt <= '0;
                                r_shift   <= w_hold_nxt;
                                DOUT      <= w_hold_nxt[DATA_W-1];
                            end else begin
                                r_bit_cnt <= r_bit_cnt + BCNT_W'(1);
                            end
                        end else if (w_sclk_fall) begin
                            r_shift <= {r_shift[DATA_W-2:0], 1'b0};
                            DOUT    <= r_shift[DATA_W-2];
                        end
                    end
                    default: r_state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_adc045_emu.sv
module tb_adc045_emu;

    localparam int CD = 100;
    localparam int DL = 4;
    localparam int H  = 5;   // SCLK half period in clk

    logic        clk = 1'b0;
    logic        rst_l = 1'b0;
    logic        SCLK = 1'b0;
    logic        CS = 1'b1;
    logic        DIN = 1'b0;
    logic        nRST = 1'b1;
    logic        START = 1'b0;
    logic [23:0] ch0 = '0;
    logic [23:0] ch1 = '0;
    logic        DOUT, DRDY, a_mux, conv_stb, reg_wr, overrun;
    logic [6:0]  reg_addr;
    logic [7:0]  reg_data;

    adc045_emu #(.DATA_W(24), .CONV_DIV(CD), .DRDY_LEN(DL)) dut (
        .clk(clk), .rst_l(rst_l), .SCLK(SCLK), .CS(CS), .DIN(DIN),
        .DOUT(DOUT), .DRDY(DRDY), .nRST(nRST), .START(START),
        .ch0_sample(ch0), .ch1_sample(ch1), .a_mux(a_mux),
        .conv_stb(conv_stb), .reg_wr(reg_wr), .reg_addr(reg_addr),
        .reg_data(reg_data), .overrun(overrun)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Event monitor, sampled mid-cycle.
    int   rise_cnt = 0, last_rise = 0, prev_rise = 0, last_width = 0;
    int   conv_cnt = 0, wr_cnt = 0, ovr_cnt = 0;
    logic drdy_q = 1'b0;
    always @(negedge clk) begin
        if (DRDY && !drdy_q) begin
            rise_cnt  <= rise_cnt + 1;
            prev_rise <= last_rise;
            last_rise <= cyc;
        end
        if (!DRDY && drdy_q) last_width <= cyc - last_rise;
        drdy_q <= DRDY;
        if (conv_stb) conv_cnt <= conv_cnt + 1;
        if (reg_wr)   wr_cnt   <= wr_cnt + 1;
        if (overrun)  ovr_cnt  <= ovr_cnt + 1;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_conv(input string nm);
        int c0 = conv_cnt;
        logic got = 1'b0;
        for (int k = 0; k < 600 && !got; k++) begin
            tick(1);
            if (conv_cnt != c0) got = 1'b1;
        end
        chk(nm, 64'(got), 64'd1);
    endtask

    task automatic wait_rise(input string nm);
        int r0 = rise_cnt;
        logic got = 1'b0;
        for (int k = 0; k < 600 && !got; k++) begin
            tick(1);
            if (rise_cnt != r0) got = 1'b1;
        end
        chk(nm, 64'(got), 64'd1);
    endtask

    // Host frame: DIN set during SCLK low, DOUT sampled just before each rise.
    task automatic spi(input logic [15:0] cmd, input int nbits, input int stop_bit,
                       output logic [23:0] data);
        data = '0;
        CS = 1'b0;
        for (int i = 0; i < nbits; i++) begin
            if (i == stop_bit) START = 1'b0;
            DIN = (i < 16) ? cmd[15-i] : 1'b0;
            tick(H);
            if (i < 24) data[23-i] = DOUT;
            SCLK = 1'b1;
            tick(H);
            SCLK = 1'b0;
        end
        tick(H);
        CS = 1'b1;
        DIN = 1'b0;
        tick(10);
    endtask

    task automatic do_txn(input logic [15:0] cmd, input logic [23:0] c0v, input logic [23:0] c1v,
                          output logic [23:0] frame, output int wrd);
        int w;
        ch0 = c0v;
        ch1 = c1v;
        START = 1'b1;
        w = wr_cnt;
        wait_conv("txn conversion");
        START = 1'b0;
        spi(cmd, 24, -1, frame);
        wrd = wr_cnt - w;
    endtask

    typedef struct {
        logic [15:0] cmd;
        logic [23:0] c0;
        logic [23:0] c1;
        logic [23:0] frame;
        int          wr;
        logic [6:0]  addr;
        logic [7:0]  data;
        logic        amux;
    } vec_t;

    vec_t tbl[8];

    initial begin
        logic [23:0] f;
        logic [31:0] r;
        logic [23:0] c0v, c1v, expf;
        logic [15:0] rc;
        int          wrd, c0, r1, cv, w, o, expwr;
        logic        m_amux;
        logic [6:0]  m_addr;
        logic [7:0]  m_data;

        tbl[0] = '{16'h0000, 24'hA55AC3, 24'h123456, 24'hA55AC3, 0, 7'h00, 8'h00, 1'b0};
        tbl[1] = '{16'h8101, 24'hA55AC3, 24'h123456, 24'hA55AC3, 1, 7'h01, 8'h01, 1'b1};
        tbl[2] = '{16'h0000, 24'hA55AC3, 24'h123456, 24'h123456, 0, 7'h01, 8'h01, 1'b1};
        tbl[3] = '{16'h0101, 24'hA55AC3, 24'h123456, 24'h123456, 0, 7'h01, 8'h01, 1'b1};
        tbl[4] = '{16'h0100, 24'h000001, 24'h800000, 24'h800000, 0, 7'h01, 8'h01, 1'b1};
        tbl[5] = '{16'h8542, 24'hFFFFFF, 24'h7FFFFE, 24'h7FFFFE, 1, 7'h05, 8'h42, 1'b1};
        tbl[6] = '{16'h8100, 24'h3C3C3C, 24'hC3C3C3, 24'hC3C3C3, 1, 7'h01, 8'h00, 1'b0};
        tbl[7] = '{16'h0000, 24'h3C3C3C, 24'hC3C3C3, 24'h3C3C3C, 0, 7'h01, 8'h00, 1'b0};

        // Reset state
        tick(3);
        chk("reset outputs", 64'({DOUT, DRDY, a_mux, conv_stb, reg_wr, overrun}), 64'd0);
        chk("reset reg_addr", 64'(reg_addr), 64'd0);
        chk("reset reg_data", 64'(reg_data), 64'd0);
        rst_l = 1'b1;
        tick(5);

        // DRDY cadence and width, conv_stb once per DRDY
        ch0 = 24'hA55AC3;
        START = 1'b1;
        cv = conv_cnt;
        c0 = rise_cnt;
        wait_rise("t1 rise a");
        wait_rise("t1 rise b");
        wait_rise("t1 rise c");
        tick(DL + 3);
        chk("t1 drdy period", 64'(last_rise - prev_rise), 64'(CD));
        chk("t1 drdy width", 64'(last_width), 64'(DL));
        chk("t1 conv_stb per drdy", 64'(conv_cnt - cv), 64'(rise_cnt - c0));
        START = 1'b0;
        tick(5);

        // Table vectors
        for (int i = 0; i < 8; i++) begin
            do_txn(tbl[i].cmd, tbl[i].c0, tbl[i].c1, f, wrd);
            chk($sformatf("vec%0d frame", i), 64'(f), 64'(tbl[i].frame));
            chk($sformatf("vec%0d reg_wr count", i), 64'(wrd), 64'(tbl[i].wr));
            chk($sformatf("vec%0d reg_addr", i), 64'(reg_addr), 64'(tbl[i].addr));
            chk($sformatf("vec%0d reg_data", i), 64'(reg_data), 64'(tbl[i].data));
            chk($sformatf("vec%0d a_mux", i), 64'(a_mux), 64'(tbl[i].amux));
        end

        // Randomised commands against the register/mux model
        m_amux = 1'b0;
        m_addr = 7'h01;
        m_data = 8'h00;
        for (int i = 0; i < 12; i++) begin
            r = $urandom; c0v = r[23:0];
            r = $urandom; c1v = r[23:0];
            r = $urandom; rc = r[15:0];
            if (r[16]) rc[14:8] = 7'h01;
            expf = m_amux ? c1v : c0v;
            expwr = 0;
            if (rc[15]) begin
                expwr = 1;
                m_addr = rc[14:8];
                m_data = rc[7:0];
                if (rc[14:8] == 7'h01) m_amux = rc[0];
            end
            do_txn(rc, c0v, c1v, f, wrd);
            chk($sformatf("rnd%0d frame", i), 64'(f), 64'(expf));
            chk($sformatf("rnd%0d reg_wr count", i), 64'(wrd), 64'(expwr));
            chk($sformatf("rnd%0d reg_addr", i), 64'(reg_addr), 64'(m_addr));
            chk($sformatf("rnd%0d reg_data", i), 64'(reg_data), 64'(m_data));
            chk($sformatf("rnd%0d a_mux", i), 64'(a_mux), 64'(m_amux));
        end

        // Overrun: conversion lands mid-frame
        ch0 = 24'hC0FFEE; ch1 = 24'hC0FFEE;
        START = 1'b1;
        wait_conv("t3 conversion");
        ch0 = 24'h5EED42; ch1 = 24'h5EED42;
        o = ovr_cnt;
        spi(16'h0000, 24, 14, f);
        chk("t3 frame intact", 64'(f), 64'h00C0FFEE);
        chk("t3 overrun count", 64'(ovr_cnt - o), 64'd1);
        spi(16'h0000, 24, -1, f);
        chk("t3 next frame", 64'(f), 64'h005EED42);

        // Aborted partial frame, then full frame of the same word
        w = wr_cnt;
        spi(16'h8101, 10, -1, f);
        spi(16'h0000, 24, -1, f);
        chk("t4 frame after abort", 64'(f), 64'h005EED42);
        chk("t4 no reg_wr", 64'(wr_cnt - w), 64'd0);
        chk("t4 a_mux unchanged", 64'(a_mux), 64'(m_amux));

        // Soft reset mid-frame
        do_txn(16'h8101, 24'h111111, 24'h222222, f, wrd);
        m_amux = 1'b1; m_addr = 7'h01; m_data = 8'h01;
        chk("t5 a_mux before", 64'(a_mux), 64'd1);
        START = 1'b1;
        wait_conv("t5 conversion");
        CS = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick(H); SCLK = 1'b1; tick(H); SCLK = 1'b0;
        end
        nRST = 1'b0;
        tick(4);
        chk("t5 nrst DRDY", 64'(DRDY), 64'd0);
        chk("t5 nrst a_mux", 64'(a_mux), 64'd0);
        chk("t5 nrst DOUT", 64'(DOUT), 64'd0);
        chk("t5 nrst keeps reg_addr", 64'(reg_addr), 64'(m_addr));
        chk("t5 nrst keeps reg_data", 64'(reg_data), 64'(m_data));
        m_amux = 1'b0;
        tick(1);
        nRST = 1'b1;
        c0 = cyc;
        CS = 1'b1;
        wait_rise("t5 first drdy");
        chk("t5 drdy after release", 64'(last_rise - c0), 64'(CD + 2));

        // START pause, then async reset mid-shift
        wait_rise("t6 rise before pause");
        r1 = last_rise;
        cv = conv_cnt;
        tick(30);
        START = 1'b0;
        tick(250);
        START = 1'b1;
        wait_rise("t6 rise after pause");
        chk("t6 paused interval", 64'(last_rise - r1), 64'(CD + 250));
        chk("t6 conv_stb during pause", 64'(conv_cnt - cv), 64'd1);
        do_txn(16'h8177, 24'hFFFFFF, 24'hFFFFFF, f, wrd);
        chk("t6 setup a_mux", 64'(a_mux), 64'd1);
        START = 1'b1;
        CS = 1'b0;
        for (int k = 0; k < 5; k++) begin
            tick(H); SCLK = 1'b1; tick(H); SCLK = 1'b0;
        end
        rst_l = 1'b0;
        #1;
        chk("t6 async reset outputs",
            64'({DOUT, DRDY, a_mux, conv_stb, reg_wr, overrun, reg_addr, reg_data}), 64'd0);
        tick(3);
        rst_l = 1'b1;
        CS = 1'b1;
        START = 1'b0;
        tick(5);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
